ic_test_group_sequencer: RTL

Parametrised successor to the test-group select decoder. Instead of statically decoding a select code into one gate-family enable, it sequences autonomously through a masked set of NUM_GROUPS IC test groups (NOT, 2-, 3-, 4-, 8-input, ...). It holds each group's one-hot enable for a programmable dwell time and samples the group's pass/fail line at the end of each dwell. It sits between the host/UI control logic and the per-family test engines, and it returns a per-group result vector plus a done pulse.

---
 rtl/ic_test_group_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ic_test_group_sequencer.sv
// Autonomous IC test-group sequencer: steps through the masked groups, holding each one-hot
// enable for DWELL_CYCLES and sampling group_pass. Define MANUAL_SEL_EN for the legacy static-select mode.
module ic_test_group_sequencer #(
  parameter int unsigned NUM_GROUPS   = 5,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DWELL_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_GROUPS-1:0] group_mask,
  input  logic                  group_pass,
`ifdef MANUAL_SEL_EN
  input  logic [SEL_W-1:0]      manual_sel,
  input  logic                  manual_mode,
`endif
  output logic [NUM_GROUPS-1:0] group_en,
  output logic [SEL_W-1:0]      sel,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_GROUPS-1:0] result,
  output logic                  any_fail
);

  typedef enum logic [1:0] {IDLE, SCAN, DWELL, DONE} state_e;

  localparam logic [SEL_W-1:0] SEL_NONE = '1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_GROUPS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_e                state_q;
  logic [SEL_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_GROUPS-1:0] mask_q;
  logic [NUM_GROUPS-1:0] group_en_q;
  logic [SEL_W-1:0]      sel_q;
  logic                  busy_q;
  logic                  done_q;
  logic [NUM_GROUPS-1:0] result_q;
  logic                  any_fail_q;
  logic                  start_ok;

  // Out-of-range codes (including all-ones) decode to no enable.
  function automatic logic [NUM_GROUPS-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [NUM_GROUPS-1:0] v;
    v = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      if (i == SEL_W'(g)) v[g] = 1'b1;
    end
    return v;
  endfunction

`ifdef MANUAL_SEL_EN
  assign start_ok = start && !abort && !manual_mode;
`else
  assign start_ok = start && !abort;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      group_en_q <= '0;
      sel_q      <= SEL_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      any_fail_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q    <= IDLE;
        group_en_q <= '0;
        sel_q      <= SEL_NONE;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
`ifdef MANUAL_SEL_EN
            if (manual_mode) begin
              group_en_q <= onehot(manual_sel);
              sel_q      <= manual_sel;
            end else begin
              group_en_q <= '0;
              sel_q      <= SEL_NONE;
            end
`endif
            if (start_ok) begin
              mask_q   <= group_mask;
              result_q <= '0;
              idx_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= SCAN;
            end
          end
          SCAN: begin
            if (mask_q[idx_q]) begin
              group_en_q <= onehot(idx_q);
              sel_q      <= idx_q;
              cnt_q      <= CNT_LOAD;
              state_q    <= DWELL;
            end else if (idx_q == LAST_IDX) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          DWELL: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              result_q[idx_q] <= group_pass;
              group_en_q      <= '0;
              sel_q           <= SEL_NONE;
              if (idx_q == LAST_IDX) begin
                state_q <= DONE;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= SCAN;
              end
            end
          end
          DONE: begin
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            any_fail_q <= |(mask_q & ~result_q);
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign group_en = group_en_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign any_fail = any_fail_q;

endmodule
